color_matrix_stage: RTL and testbench

//  Pipelined 3x3 colour-correction stage on the RGB pixel bus. Three
//  dot_product3 instances (A unsigned pixel, B signed coeff) produce the raw

---
 rtl/color_matrix_stage.sv | 207 ++++++++++++++++++++
 tb/tb_color_matrix_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_matrix_stage.sv
// 3x3 colour-correction stage: registers the pixel, forms three signed dot
// products, then rounds half-up, scales by the fractional bits and clamps
// the result back to pixel width. Coefficient updates wait for a frame gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no update waiting; active coefficients are current
// PENDING | new coefficients captured; commit at the first cycle fvi=0

module dot_product3 #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COEFF_WIDTH = 9,
  parameter int SUM_WIDTH   = 19
) (
  input  logic [3*PIXEL_WIDTH-1:0]     a,
  input  logic [3*COEFF_WIDTH-1:0]     b,
  output logic signed [SUM_WIDTH-1:0]  sum
);

  function automatic logic signed [SUM_WIDTH-1:0] mul(
    input logic [PIXEL_WIDTH-1:0]        p,
    input logic signed [COEFF_WIDTH-1:0] c
  );
    logic signed [SUM_WIDTH-1:0] pe;
    logic signed [SUM_WIDTH-1:0] ce;
    pe = {{(SUM_WIDTH-PIXEL_WIDTH){1'b0}}, p};
    ce = {{(SUM_WIDTH-COEFF_WIDTH){c[COEFF_WIDTH-1]}}, c};
    return pe * ce;
  endfunction

  // Sum of unsigned pixel times signed coefficient over three components.
  always_comb begin
    sum = mul(a[0*PIXEL_WIDTH +: PIXEL_WIDTH], b[0*COEFF_WIDTH +: COEFF_WIDTH])
        + mul(a[1*PIXEL_WIDTH +: PIXEL_WIDTH], b[1*COEFF_WIDTH +: COEFF_WIDTH])
        + mul(a[2*PIXEL_WIDTH +: PIXEL_WIDTH], b[2*COEFF_WIDTH +: COEFF_WIDTH]);
  end

endmodule

module color_matrix_stage #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COEFF_WIDTH = 9,
  parameter int FRAC_BITS   = 6
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     enable,
  input  logic [9*COEFF_WIDTH-1:0] coeff,
  input  logic                     coeff_ld,
  input  logic                     fvi,
  input  logic                     lvi,
  input  logic                     dvi,
  input  logic [PIXEL_WIDTH-1:0]   r_in,
  input  logic [PIXEL_WIDTH-1:0]   g_in,
  input  logic [PIXEL_WIDTH-1:0]   b_in,
  output logic                     fvo,
  output logic                     lvo,
  output logic                     dvo,
  output logic [PIXEL_WIDTH-1:0]   r_out,
  output logic [PIXEL_WIDTH-1:0]   g_out,
  output logic [PIXEL_WIDTH-1:0]   b_out,
  output logic                     coeff_busy
);

  localparam int SW = PIXEL_WIDTH + COEFF_WIDTH + 2;
  localparam int CV = 9 * COEFF_WIDTH;
  localparam logic signed [SW-1:0] HALF = SW'(1 << (FRAC_BITS - 1));
  localparam logic signed [SW-1:0] PMAX = SW'((1 << PIXEL_WIDTH) - 1);

  function automatic logic [CV-1:0] identity_coeffs();
    logic [CV-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      v[(i*4)*COEFF_WIDTH +: COEFF_WIDTH] = COEFF_WIDTH'(1 << FRAC_BITS);
    end
    return v;
  endfunction

  localparam logic [CV-1:0] IDENTITY = identity_coeffs();

  typedef enum logic {ST_IDLE, ST_PENDING} coeff_state_t;

  coeff_state_t state_q, state_d;
  logic         capture, commit;
  logic [CV-1:0] pend_q, act_q;

  logic                   s1_fv, s1_lv, s1_dv, s1_en;
  logic [PIXEL_WIDTH-1:0] s1_r, s1_g, s1_b;
  logic [CV-1:0]          s1_coeff;

  logic signed [SW-1:0]   sums [3];
  logic signed [SW-1:0]   scaled [3];
  logic [PIXEL_WIDTH-1:0] corr [3];

  // Coefficient update sequencing; a new load wins over a same-cycle commit.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coeff_ld) begin
          capture = 1'b1;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (coeff_ld) begin
          capture = 1'b1;
        end else if (!fvi) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign coeff_busy = (state_q == ST_PENDING);

  // Coefficient registers and FSM state; reset restores identity.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      pend_q  <= IDENTITY;
      act_q   <= IDENTITY;
    end else begin
      state_q <= state_d;
      if (capture) pend_q <= coeff;
      if (commit)  act_q  <= pend_q;
    end
  end

  // Stage 1: capture pixel, mode and the coefficients it will be scaled by.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      s1_fv    <= 1'b0;
      s1_lv    <= 1'b0;
      s1_dv    <= 1'b0;
      s1_en    <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_coeff <= IDENTITY;
    end else begin
      s1_fv <= fvi;
      s1_lv <= lvi;
      s1_dv <= dvi;
      if (dvi) begin
        s1_en    <= enable;
        s1_r     <= r_in;
        s1_g     <= g_in;
        s1_b     <= b_in;
        s1_coeff <= act_q;
      end
    end
  end

  for (genvar row = 0; row < 3; row++) begin : g_row
    dot_product3 #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .COEFF_WIDTH (COEFF_WIDTH),
      .SUM_WIDTH   (SW)
    ) u_dot (
      .a   ({s1_b, s1_g, s1_r}),
      .b   (s1_coeff[row*3*COEFF_WIDTH +: 3*COEFF_WIDTH]),
      .sum (sums[row])
    );
  end

  // Half-up rounding, arithmetic scale-down and clamp to [0, 2^PW-1].
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      scaled[i] = (sums[i] + HALF) >>> FRAC_BITS;
      corr[i]   = '0;
      if (scaled[i] < 0) begin
        corr[i] = '0;
      end else if (scaled[i] > PMAX) begin
        corr[i] = '1;
      end else begin
        corr[i] = scaled[i][PIXEL_WIDTH-1:0];
      end
    end
  end

  // Stage 2: output registers; pixel data holds while no valid pixel arrives.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      fvo   <= 1'b0;
      lvo   <= 1'b0;
      dvo   <= 1'b0;
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
    end else begin
      fvo <= s1_fv;
      lvo <= s1_lv;
      dvo <= s1_dv;
      if (s1_dv) begin
        r_out <= s1_en ? corr[0] : s1_r;
        g_out <= s1_en ? corr[1] : s1_g;
        b_out <= s1_en ? corr[2] : s1_b;
      end
    end
  end

endmodule

// File: tb/tb_color_matrix_stage.sv
// Bench for color_matrix_stage: directed cases with literal expectations,
// then randomized traffic compared cycle by cycle against a reference model.

module tb_color_matrix_stage;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b1;
  logic [80:0] coeff = '0;
  logic        coeff_ld = 1'b0;
  logic        fvi = 1'b0, lvi = 1'b0, dvi = 1'b0;
  logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
  logic        fvo, lvo, dvo, coeff_busy;
  logic [7:0]  r_out, g_out, b_out;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  color_matrix_stage dut (
    .clk        (clk),
    .resetb     (resetb),
    .enable     (enable),
    .coeff      (coeff),
    .coeff_ld   (coeff_ld),
    .fvi        (fvi),
    .lvi        (lvi),
    .dvi        (dvi),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .fvo        (fvo),
    .lvo        (lvo),
    .dvo        (dvo),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .coeff_busy (coeff_busy)
  );

  function automatic logic [80:0] mk(input int c00, c01, c02, c10, c11, c12,
                                     c20, c21, c22);
    int c[9];
    logic [80:0] v;
    c = '{c00, c01, c02, c10, c11, c12, c20, c21, c22};
    v = '0;
    for (int k = 0; k < 9; k++) v[k*9 +: 9] = 9'(c[k]);
    return v;
  endfunction

  function automatic int coeff_of(input logic [80:0] v, input int k);
    logic signed [8:0] c;
    c = v[k*9 +: 9];
    return int'(c);
  endfunction

  // Matrix row applied with plain integer arithmetic: round half up, clamp.
  function automatic int corrected(input int p0, p1, p2, input int c0, c1, c2);
    int s, t;
    s = p0 * c0 + p1 * c1 + p2 * c2;
    t = (s + 32) >>> 6;
    if (t < 0) return 0;
    if (t > 255) return 255;
    return t;
  endfunction

  // Reference model state: coefficient sets, in-flight pixel, expected outputs.
  int act_m[9], pend_m[9];
  bit busy_m;
  bit m_fv, m_lv, m_dv;
  int m_px[3];
  bit e_fv, e_lv, e_dv;
  int e_px[3];

  always @(posedge clk) begin
    int pin[3];
    pin = '{int'(r_in), int'(g_in), int'(b_in)};
    if (!resetb) begin
      for (int k = 0; k < 9; k++) begin
        act_m[k]  = (k % 4 == 0) ? 64 : 0;
        pend_m[k] = act_m[k];
      end
      busy_m = 1'b0;
      {m_fv, m_lv, m_dv} = 3'b000;
      {e_fv, e_lv, e_dv} = 3'b000;
      m_px = '{0, 0, 0};
      e_px = '{0, 0, 0};
    end else begin
      e_fv = m_fv;
      e_lv = m_lv;
      e_dv = m_dv;
      if (m_dv) e_px = m_px;
      m_fv = fvi;
      m_lv = lvi;
      m_dv = dvi;
      if (dvi) begin
        for (int i = 0; i < 3; i++) begin
          m_px[i] = enable ? corrected(pin[0], pin[1], pin[2],
                                       act_m[i*3], act_m[i*3+1], act_m[i*3+2])
                           : pin[i];
        end
      end
      if (coeff_ld) begin
        for (int k = 0; k < 9; k++) pend_m[k] = coeff_of(coeff, k);
        busy_m = 1'b1;
      end else if (busy_m && !fvi) begin
        act_m  = pend_m;
        busy_m = 1'b0;
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      n_chk++;
      if (fvo !== e_fv || lvo !== e_lv || dvo !== e_dv || coeff_busy !== busy_m ||
          int'(r_out) != e_px[0] || int'(g_out) != e_px[1] || int'(b_out) != e_px[2] ||
          $isunknown({r_out, g_out, b_out})) begin
        n_err++;
        $display("FAIL cycle_check t=%0t got fv/lv/dv=%b%b%b rgb=%0d,%0d,%0d busy=%b want %b%b%b %0d,%0d,%0d busy=%b",
                 $time, fvo, lvo, dvo, r_out, g_out, b_out, coeff_busy,
                 e_fv, e_lv, e_dv, e_px[0], e_px[1], e_px[2], busy_m);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pix(input int r, input int g, input int b);
    r_in = 8'(r); g_in = 8'(g); b_in = 8'(b);
    dvi = 1'b1;
    step();
    dvi = 1'b0;
    step();
  endtask

  task automatic load(input logic [80:0] v);
    coeff = v;
    coeff_ld = 1'b1;
    step();
    coeff_ld = 1'b0;
  endtask

  initial begin
    logic [80:0] swap;
    swap = mk(0, 0, 64, 0, 64, 0, 64, 0, 0);

    resetb = 1'b0;
    step(); step();
    chk("reset_r_out", int'(r_out), 0);
    chk("reset_dvo", int'(dvo), 0);
    chk("reset_busy", int'(coeff_busy), 0);
    chk_on = 1'b1;
    resetb = 1'b1;
    fvi = 1'b1; lvi = 1'b1;

    // identity pass-through
    pix(10, 200, 255);
    chk("ident_r", int'(r_out), 10);
    chk("ident_g", int'(g_out), 200);
    chk("ident_b", int'(b_out), 255);

    // load during frame gap: one cycle busy, then rounding case
    fvi = 1'b0; lvi = 1'b0;
    load(mk(32, 32, 0, 0, 64, 0, 0, 0, 64));
    chk("gap_busy_set", int'(coeff_busy), 1);
    step();
    chk("gap_busy_clr", int'(coeff_busy), 0);
    fvi = 1'b1; lvi = 1'b1;
    pix(100, 101, 0);
    chk("round_r", int'(r_out), 101);
    chk("round_g", int'(g_out), 101);

    // clamp low and high
    fvi = 1'b0;
    load(mk(-128, 0, 0, 0, 64, 0, 0, 0, 64));
    step();
    fvi = 1'b1;
    pix(50, 0, 0);
    chk("clamp_low", int'(r_out), 0);
    fvi = 1'b0;
    load(mk(255, 0, 0, 0, 64, 0, 0, 0, 64));
    step();
    fvi = 1'b1;
    pix(200, 0, 0);
    chk("clamp_high", int'(r_out), 255);

    // mid-frame load waits for fvi to drop
    load(swap);
    chk("frame_busy", int'(coeff_busy), 1);
    repeat (3) step();
    chk("frame_busy_hold", int'(coeff_busy), 1);
    pix(1, 2, 3);
    chk("old_coeff_r", int'(r_out), 4);
    chk("old_coeff_b", int'(b_out), 3);
    fvi = 1'b0; lvi = 1'b0;
    step();
    chk("commit_busy", int'(coeff_busy), 0);
    fvi = 1'b1; lvi = 1'b1;
    pix(1, 2, 3);
    chk("new_coeff_r", int'(r_out), 3);
    chk("new_coeff_b", int'(b_out), 1);

    // bypass and mid-line enable toggle
    enable = 1'b0;
    pix(7, 8, 9);
    chk("bypass_r", int'(r_out), 7);
    chk("bypass_b", int'(b_out), 9);
    r_in = 8'd20; g_in = 8'd30; b_in = 8'd40;
    dvi = 1'b1; enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    dvi = 1'b0;
    chk("toggle_first_bypass", int'(r_out), 20);
    step();
    chk("toggle_second_swap", int'(r_out), 40);
    for (int i = 0; i < 8; i++) begin
      r_in = 8'($urandom_range(0, 255));
      g_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
      enable = i[0];
      dvi = 1'b1;
      step();
    end
    dvi = 1'b0;
    step(); step();

    // reset mid-line with an update pending
    enable = 1'b1;
    load(mk(0, 64, 0, 0, 64, 0, 0, 0, 64));
    r_in = 8'd90; dvi = 1'b1;
    step();
    resetb = 1'b0;
    step();
    chk("rst_r_out", int'(r_out), 0);
    chk("rst_dvo", int'(dvo), 0);
    chk("rst_busy", int'(coeff_busy), 0);
    resetb = 1'b1; dvi = 1'b0;
    step();
    chk("rst_dvo_after", int'(dvo), 0);
    pix(10, 20, 30);
    chk("rst_ident_r", int'(r_out), 10);
    chk("rst_ident_b", int'(b_out), 30);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      resetb = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 39) == 0) fvi = ~fvi;
      lvi = fvi & ($urandom_range(0, 7) != 0);
      dvi = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      coeff_ld = ($urandom_range(0, 24) == 0);
      if (coeff_ld) begin
        for (int k = 0; k < 9; k++) begin
          if ($urandom_range(0, 1) == 0)
            coeff[k*9 +: 9] = 9'($urandom_range(0, 511));
          else
            coeff[k*9 +: 9] = 9'(((k % 4 == 0) ? 48 : -16) + int'($urandom_range(0, 32)));
        end
      end
      r_in = 8'($urandom_range(0, 255));
      g_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
      step();
    end
    resetb = 1'b1; coeff_ld = 1'b0; dvi = 1'b0;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
